// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller driving one shared 1-bit full adder, LSB first.
// Result is ready WIDTH edges after start is accepted; start is ignored while busy or done.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s, fa_cout;
  logic [WIDTH-1:0] acc_full;

  // Subtract feeds the inverted B bit; the +1 comes from the preset carry.
  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0] ^ op_q),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Only WIDTH-1 earlier bits need storing; the final bit goes straight into sum.
  assign acc_full = {fa_s, s_sh_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = op ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = acc_full[WIDTH-1:1];
        carry_d = fa_cout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = acc_full;
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cout;
  logic [7:0] sum;

  int cyc = 0;
  int done_cnt = 0;
  int n_assert = 0;
  int n_fail = 0;
  int k_cyc = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic oi);
    @(negedge clk);
    a = ai; b = bi; cin = ci; op = oi; start = 1'b1;
    @(posedge clk);
    #1;
    k_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int bc);
    l = -1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        l = cyc - k_cyc;
        break;
      end
      if (busy) bc++;
    end
  endtask

  initial begin
    int lat, bcyc, dc, seen, acc2;
    logic [7:0] ra, rb;
    logic rc, ro;
    logic [8:0] exp9;

    // Reset with start asserted: reset wins
    start = 1'b1; a = 8'hFF; b = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    // Add with full carry, with detailed timing
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat, bcyc);
    chk("add_ff_lat", lat, 8);
    chk("add_ff_busy_cycles", bcyc, 8);
    chk("add_ff_busy_at_done", busy, 0);
    chk("add_ff_res", {cout, sum}, 9'h100);
    @(negedge clk);
    chk("add_ff_done_pulse", done, 0);
    chk("add_ff_hold", {cout, sum}, 9'h100);

    // Add with carry-in
    launch(8'h5A, 8'h33, 1'b1, 1'b0);
    wait_done(lat, bcyc);
    chk("add_cin_lat", lat, 8);
    chk("add_cin_res", {cout, sum}, 9'h08E);

    // Subtract both ways, cin ignored
    launch(8'h10, 8'h20, 1'b1, 1'b1);
    wait_done(lat, bcyc);
    chk("sub_borrow_res", {cout, sum}, 9'h0F0);
    launch(8'h20, 8'h10, 1'b1, 1'b1);
    wait_done(lat, bcyc);
    chk("sub_noborrow_res", {cout, sum}, 9'h110);

    // Start pulse and operand changes during RUN are ignored
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcyc);
    chk("ignore_lat", lat, 8);
    chk("ignore_res", {cout, sum}, 9'h002);
    dc = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) dc++;
    end
    chk("ignore_no_requeue", dc, 0);

    // Start held high re-triggers at k+10
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    k_cyc = cyc;
    seen = 0;
    acc2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (seen == 1 && busy) begin
        acc2 = cyc - k_cyc;
        break;
      end
    end
    start = 1'b0;
    chk("hold_reaccept", acc2, 10);
    k_cyc = k_cyc + 10;
    wait_done(lat, bcyc);
    chk("hold_second_lat", lat, 8);
    chk("hold_second_res", {cout, sum}, 9'h002);

    // Reset at k+4 aborts the operation
    launch(8'h37, 8'h11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    dc = done_cnt;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    launch(8'h5A, 8'h33, 1'b1, 1'b0);
    wait_done(lat, bcyc);
    chk("after_abort_lat", lat, 8);
    chk("after_abort_res", {cout, sum}, 9'h08E);

    // Random sweep against reference model
    @(negedge clk);
    dc = done_cnt;
    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      exp9 = ro ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1)
                : ({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      launch(ra, rb, rc, ro);
      wait_done(lat, bcyc);
      chk("rand_res", {cout, sum}, exp9);
    end
    repeat (2) @(negedge clk);
    chk("rand_done_count", done_cnt - dc, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller that sequences a single 1-bit `full_adder` cell over `WIDTH` clock cycles to add or subtract two `WIDTH`-bit operands, LSB first. It sits between a requesting datapath and the shared 1-bit adder cell. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. The result is presented as a registered parallel word plus carry-out.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = add (`a + b + cin`), 1 = subtract (`a - b`, computed as `a + ~b + 1`; `cin` ignored).
- `a`  in  `WIDTH`  operand A; captured when `start` is accepted.
- `b`  in  `WIDTH`  operand B; captured when `start` is accepted.
- `cin`  in  1  carry-in for add; captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse when the result registers update.
- `sum`  out  `WIDTH`  registered result.
- `cout`  out  1  registered carry-out; for subtract, 1 = no borrow (`a >= b` unsigned).

## Operation
- Instantiates one `full_adder` cell. Its `a` input is A_sh[0], its `b` input is B_sh[0] XOR op_q, and its `cin` input is the carry flip-flop.
- FSM states:
  - IDLE: wait for `start`.
  - RUN: process one bit per cycle.
  - DONE: one cycle; `done` is high; return to IDLE.
- IDLE with `start`=1:
  - A_sh <= `a`, B_sh <= `b`, op_q <= `op`.
  - carry <= (`op` ? 1 : `cin`).
  - bit counter <= 0; go to RUN.
- IDLE with `start`=0: hold.
- RUN, each cycle:
  - A_sh and B_sh shift right by 1.
  - Adder sum bit shifts into the MSB of the accumulator register S_sh.
  - carry <= adder cout; counter increments.
- RUN exit: when counter == `WIDTH`-1, the cycle's final bit is processed and the FSM goes to DONE.
- Result update: on that same edge, `sum` <= the full shifted accumulator (including the final bit) and `cout` <= the final adder cout.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored in DONE and in RUN (no queuing).
- `sum` and `cout` change only on the RUN-to-DONE edge. They hold until the next completed operation.
- Operand inputs are don't-care after capture; changing them during RUN does not affect the result.
- Counter width is `$clog2(WIDTH)`; no wrap occurs beyond `WIDTH`-1.
- Reset (any state, including mid-RUN):
  - state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Shift registers, carry and counter cleared.
  - An aborted operation produces no `done` and leaves `sum` = 0.

## Timing
- Let edge k be the edge where `start` is accepted in IDLE.
- `busy` is high from edge k to edge k+`WIDTH`, i.e. exactly `WIDTH` cycles.
- `sum` and `cout` are valid, and `done` is high, from edge k+`WIDTH` to edge k+`WIDTH`+1.
- Latency: `WIDTH`+1 edges from acceptance to the end of the `done` pulse.
- Earliest next acceptance is edge k+`WIDTH`+2, giving a throughput of one operation per `WIDTH`+2 cycles.
- `start` held high continuously re-triggers at edges k, k+`WIDTH`+2, and so on.
- `reset` takes priority over `start` on the same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `WIDTH`=8.
- Add with full carry: `a`=0xFF, `b`=0x01, `cin`=0, `op`=0 -> `sum`=0x00, `cout`=1. `done` is high exactly at edge k+8 for one cycle; `busy` is high for 8 cycles.
- Add with carry-in: `a`=0x5A, `b`=0x33, `cin`=1, `op`=0 -> `sum`=0x8E, `cout`=0.
- Subtract both directions, with `cin`=1 to prove it is ignored:
  - `a`=0x10, `b`=0x20, `op`=1 -> `sum`=0xF0, `cout`=0 (borrow).
  - `a`=0x20, `b`=0x10, `op`=1 -> `sum`=0x10, `cout`=1.
- Busy/done handling, starting from `a`=0x01, `b`=0x01:
  - Pulse `start` again with `a`=0xAA at k+3 -> ignored; `sum`=0x02.
  - Change `a`/`b` during RUN -> no effect on the result.
  - Hold `start` high -> second acceptance occurs exactly at k+10.
- Reset mid-operation: assert `reset` at k+4 -> next cycle `busy`=0, `done`=0, `sum`=0x00, `cout`=0, and no later `done`. A new `start` afterwards completes normally.
- Randomized sweep: 500 random `a`/`b`/`cin`/`op` -> {`cout`,`sum`} matches the reference model (`a+b+cin`, or `a+~b+1`), with one `done` per accepted start.
